// File: rtl/alu_pkg.sv
// ---------------------------------------------------------------------------
// alu_pkg
// Shared definitions for the serial arithmetic blocks.
//   DEF_WIDTH / DEF_CHUNK : default operand width and bits processed per cycle
//   state_e               : control states of the serial subtractor
// ---------------------------------------------------------------------------
package alu_pkg;

   localparam int DEF_WIDTH = 16;
   localparam int DEF_CHUNK = 4;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_e;

endpackage : alu_pkg

// File: rtl/chunk_adder.sv
// ---------------------------------------------------------------------------
// chunk_adder
// Purely combinational CHUNK-bit adder with carry in and carry out.
//   a, b : CHUNK-bit addends
//   cin  : carry in
//   s    : CHUNK-bit sum
//   cout : carry out of the top bit
// ---------------------------------------------------------------------------
module chunk_adder #(
   parameter int CHUNK = 4
) (
   input  logic [CHUNK-1:0] a,
   input  logic [CHUNK-1:0] b,
   input  logic             cin,
   output logic [CHUNK-1:0] s,
   output logic             cout
);

   always_comb begin
      {cout, s} = {1'b0, a} + {1'b0, b} + {{CHUNK{1'b0}}, cin};
   end

endmodule : chunk_adder

// File: rtl/serial_subtractor.sv
// ---------------------------------------------------------------------------
// serial_subtractor
// Computes A - B one CHUNK-bit slice per clock (LSB slice first) as
// A + ~B + 1, with a valid/ready handshake on both sides.
//   clk       : clock, rising edge
//   rst_n     : asynchronous active-low reset
//   in_valid  : operands A/B present       in_ready  : block is idle
//   A, B      : minuend / subtrahend       D         : difference mod 2^WIDTH
//   out_valid : result present             out_ready : consumer takes result
//   Borrow    : unsigned A < B             Overflow  : signed overflow of A - B
// Build option: define SERIAL_SUBTRACTOR_SAT_EN to saturate D on signed
// overflow (most positive value if A is non-negative, else most negative).
// ---------------------------------------------------------------------------
module serial_subtractor
   import alu_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH,
   parameter int CHUNK = DEF_CHUNK
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] D,
   output logic             Borrow,
   output logic             Overflow
);

   localparam int NCHUNK = WIDTH / CHUNK;
   localparam int CNT_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
   localparam logic [CNT_W-1:0] LAST = CNT_W'(NCHUNK - 1);

   if ((WIDTH % CHUNK) != 0 || WIDTH < 2) begin : g_bad_param
      $error("serial_subtractor: WIDTH must be >= 2 and a multiple of CHUNK");
   end

   state_e             state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [WIDTH-1:0]   a_q, a_d;        // minuend, progressively replaced by the sum
   logic [WIDTH-1:0]   b_q, b_d;        // inverted subtrahend, shifted down
   logic               carry_q, carry_d;
   logic               a_msb_q, a_msb_d;
   logic               b_msb_q, b_msb_d;
   logic [WIDTH-1:0]   d_q, d_d;
   logic               borrow_q, borrow_d;
   logic               ovf_q, ovf_d;

   logic [CHUNK-1:0]   slice_s;
   logic               slice_c;
   logic [WIDTH-1:0]   a_shift;
   logic [WIDTH-1:0]   b_shift;
   logic               ovf_w;
   logic [WIDTH-1:0]   sat_val;

   // One adder shared by every slice: the low CHUNK bits of the operand
   // registers always hold the slice currently being added.
   chunk_adder #(.CHUNK(CHUNK)) u_chunk_adder (
      .a    (a_q[CHUNK-1:0]),
      .b    (b_q[CHUNK-1:0]),
      .cin  (carry_q),
      .s    (slice_s),
      .cout (slice_c)
   );

   // The sum slice enters at the top of a_q as the consumed minuend slice
   // leaves at the bottom, so after NCHUNK cycles a_q holds the raw result.
   if (NCHUNK > 1) begin : g_multi
      assign a_shift = {slice_s, a_q[WIDTH-1:CHUNK]};
      assign b_shift = {{CHUNK{1'b0}}, b_q[WIDTH-1:CHUNK]};
   end else begin : g_single
      assign a_shift = slice_s;
      assign b_shift = '0;
   end

   always_comb begin
      ovf_w   = (a_msb_q != b_msb_q) && (a_shift[WIDTH-1] != a_msb_q);
      sat_val = a_msb_q ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
   end

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      a_d      = a_q;
      b_d      = b_q;
      carry_d  = carry_q;
      a_msb_d  = a_msb_q;
      b_msb_d  = b_msb_q;
      d_d      = d_q;
      borrow_d = borrow_q;
      ovf_d    = ovf_q;

      case (state_q)
         IDLE: begin
            if (in_valid) begin
               state_d = RUN;
               cnt_d   = '0;
               a_d     = A;
               b_d     = ~B;
               carry_d = 1'b1;
               a_msb_d = A[WIDTH-1];
               b_msb_d = B[WIDTH-1];
            end
         end
         RUN: begin
            a_d     = a_shift;
            b_d     = b_shift;
            carry_d = slice_c;
            if (cnt_q == LAST) begin
               // Counter holds at LAST; it is only restarted by the next accept.
               state_d  = DONE;
               borrow_d = ~slice_c;
               ovf_d    = ovf_w;
`ifdef SERIAL_SUBTRACTOR_SAT_EN
               d_d      = ovf_w ? sat_val : a_shift;
`else
               d_d      = a_shift;
`endif
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         DONE: begin
            if (out_ready) begin
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         cnt_q    <= '0;
         a_q      <= '0;
         b_q      <= '0;
         carry_q  <= 1'b0;
         a_msb_q  <= 1'b0;
         b_msb_q  <= 1'b0;
         d_q      <= '0;
         borrow_q <= 1'b0;
         ovf_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         a_q      <= a_d;
         b_q      <= b_d;
         carry_q  <= carry_d;
         a_msb_q  <= a_msb_d;
         b_msb_q  <= b_msb_d;
         d_q      <= d_d;
         borrow_q <= borrow_d;
         ovf_q    <= ovf_d;
      end
   end

   assign in_ready  = (state_q == IDLE);
   assign out_valid = (state_q == DONE);
   assign D         = d_q;
   assign Borrow    = borrow_q;
   assign Overflow  = ovf_q;

endmodule : serial_subtractor

// File: tb/tb_serial_subtractor.sv
// ---------------------------------------------------------------------------
// tb_serial_subtractor
// Self-checking bench for serial_subtractor (default WIDTH=16, CHUNK=4).
// Expected results are queued when operands are accepted and compared when
// the block presents its result. Honours SERIAL_SUBTRACTOR_SAT_EN.
// ---------------------------------------------------------------------------
module tb_serial_subtractor;

   localparam int W = 16;

   typedef struct packed {
      logic [W-1:0] d;
      logic         bor;
      logic         ovf;
   } exp_t;

   logic         clk       = 1'b0;
   logic         rst_n     = 1'b0;
   logic         in_valid  = 1'b0;
   logic         out_ready = 1'b0;
   logic [W-1:0] A         = '0;
   logic [W-1:0] B         = '0;
   logic         in_ready;
   logic         out_valid;
   logic [W-1:0] D;
   logic         Borrow;
   logic         Overflow;

   exp_t sb[$];
   int   total = 0;
   int   bad   = 0;

   serial_subtractor dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .A         (A),
      .B         (B),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .D         (D),
      .Borrow    (Borrow),
      .Overflow  (Overflow)
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached, got no finish, need finish");
      $fatal(1);
   end

   // Reference arithmetic on whole words.
   function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b);
      exp_t         e;
      logic [W-1:0] raw;
      raw   = a - b;
      e.bor = (a < b);
      e.ovf = (a[W-1] != b[W-1]) && (raw[W-1] != a[W-1]);
      e.d   = raw;
`ifdef SERIAL_SUBTRACTOR_SAT_EN
      if (e.ovf) e.d = a[W-1] ? 16'h8000 : 16'h7FFF;
`endif
      return e;
   endfunction

   // Present operands and wait (bounded) for the accepting edge; pushes the
   // expectation at that edge. Returns at accept edge + 1.
   task automatic send(input logic [W-1:0] a, input logic [W-1:0] b,
                       input exp_t e, output bit ok);
      int guard;
      guard    = 0;
      in_valid = 1'b1;
      A        = a;
      B        = b;
      while (in_ready !== 1'b1 && guard < 50) begin
         @(posedge clk); #1;
         guard++;
      end
      ok = (in_ready === 1'b1);
      if (ok) begin
         @(posedge clk);
         sb.push_back(e);
         #1;
      end
      in_valid = 1'b0;
   endtask

   // Count edges from the accept until out_valid (bounded). Optionally
   // scrambles A/B/in_valid while the operation is still running.
   task automatic wait_out(input bit scramble, output int lat);
      lat = 0;
      while (out_valid !== 1'b1 && lat < 20) begin
         @(posedge clk); #1;
         lat++;
         if (scramble && out_valid !== 1'b1) begin
            A        = W'($urandom);
            B        = W'($urandom);
            in_valid = 1'($urandom_range(0, 1));
         end
      end
      in_valid = 1'b0;
   endtask

   task automatic pop_exp(output exp_t e);
      if (sb.size() > 0) e = sb.pop_front();
      else               e = '{d: 16'hDEAD, bor: 1'bx, ovf: 1'bx};
   endtask

   task automatic take_result;
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
   endtask

   task automatic test_reset;
      rst_n = 1'b0;
      #2;
      total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%b want=1", in_ready); end
      total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%b want=0", out_valid); end
      total++; if (D !== 16'h0000) begin bad++; $display("FAIL reset_D got=%h want=0000", D); end
      total++; if (Borrow !== 1'b0) begin bad++; $display("FAIL reset_Borrow got=%b want=0", Borrow); end
      total++; if (Overflow !== 1'b0) begin bad++; $display("FAIL reset_Overflow got=%b want=0", Overflow); end
      #20;
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk); #1;
      $display("reset: in_ready=%b out_valid=%b D=%h", in_ready, out_valid, D);
   endtask

   task automatic test_basic;
      exp_t e;
      bit   ok;
      int   lat;
      send(16'h0005, 16'h0007, '{d: 16'hFFFE, bor: 1'b1, ovf: 1'b0}, ok);
      total++; if (!ok) begin bad++; $display("FAIL basic_accept got=no_accept want=accept"); end
      wait_out(1'b0, lat);
      pop_exp(e);
      total++; if (lat !== 4) begin bad++; $display("FAIL basic_latency got=%0d want=4", lat); end
      total++; if (D !== e.d) begin bad++; $display("FAIL basic_D got=%h want=%h", D, e.d); end
      total++; if (Borrow !== e.bor) begin bad++; $display("FAIL basic_Borrow got=%b want=%b", Borrow, e.bor); end
      total++; if (Overflow !== e.ovf) begin bad++; $display("FAIL basic_Overflow got=%b want=%b", Overflow, e.ovf); end
      total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL basic_in_ready_done got=%b want=0", in_ready); end
      $display("basic: A=0005 B=0007 D=%h Borrow=%b Overflow=%b lat=%0d", D, Borrow, Overflow, lat);
      take_result();
      total++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
         bad++; $display("FAIL basic_return_idle got in_ready=%b out_valid=%b want 1/0", in_ready, out_valid);
      end
   endtask

   task automatic test_overflow;
      logic [W-1:0] ta [2];
      logic [W-1:0] tb [2];
      exp_t         te [2];
      exp_t         e;
      bit           ok;
      int           lat;
      ta[0] = 16'h8000; tb[0] = 16'h0001;
      ta[1] = 16'h7FFF; tb[1] = 16'hFFFF;
`ifdef SERIAL_SUBTRACTOR_SAT_EN
      te[0] = '{d: 16'h8000, bor: 1'b0, ovf: 1'b1};
      te[1] = '{d: 16'h7FFF, bor: 1'b1, ovf: 1'b1};
`else
      te[0] = '{d: 16'h7FFF, bor: 1'b0, ovf: 1'b1};
      te[1] = '{d: 16'h8000, bor: 1'b1, ovf: 1'b1};
`endif
      for (int i = 0; i < 2; i++) begin
         send(ta[i], tb[i], te[i], ok);
         total++; if (!ok) begin bad++; $display("FAIL ovf%0d_accept got=no_accept want=accept", i); end
         wait_out(1'b0, lat);
         pop_exp(e);
         total++; if (lat !== 4) begin bad++; $display("FAIL ovf%0d_latency got=%0d want=4", i, lat); end
         total++; if (D !== e.d) begin bad++; $display("FAIL ovf%0d_D got=%h want=%h", i, D, e.d); end
         total++; if (Borrow !== e.bor) begin bad++; $display("FAIL ovf%0d_Borrow got=%b want=%b", i, Borrow, e.bor); end
         total++; if (Overflow !== e.ovf) begin bad++; $display("FAIL ovf%0d_Overflow got=%b want=%b", i, Overflow, e.ovf); end
         $display("overflow: A=%h B=%h D=%h Borrow=%b Overflow=%b", ta[i], tb[i], D, Borrow, Overflow);
         take_result();
      end
   endtask

   task automatic test_backpressure;
      exp_t e;
      bit   ok;
      int   lat;
      send(16'h1234, 16'h1234, '{d: 16'h0000, bor: 1'b0, ovf: 1'b0}, ok);
      total++; if (!ok) begin bad++; $display("FAIL bp_accept got=no_accept want=accept"); end
      wait_out(1'b0, lat);
      pop_exp(e);
      total++; if (lat !== 4) begin bad++; $display("FAIL bp_latency got=%0d want=4", lat); end
      for (int c = 0; c < 10; c++) begin
         total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL bp_out_valid cyc=%0d got=%b want=1", c, out_valid); end
         total++; if (D !== e.d) begin bad++; $display("FAIL bp_D cyc=%0d got=%h want=%h", c, D, e.d); end
         total++; if (Borrow !== e.bor) begin bad++; $display("FAIL bp_Borrow cyc=%0d got=%b want=%b", c, Borrow, e.bor); end
         total++; if (Overflow !== e.ovf) begin bad++; $display("FAIL bp_Overflow cyc=%0d got=%b want=%b", c, Overflow, e.ovf); end
         @(posedge clk); #1;
      end
      $display("backpressure: A=1234 B=1234 D=%h held 10 cycles", D);
      take_result();
   endtask

   task automatic test_reset_midrun;
      exp_t e;
      bit   ok;
      int   lat;
      int   seen;
      send(16'h4321, 16'h1111, model(16'h4321, 16'h1111), ok);
      total++; if (!ok) begin bad++; $display("FAIL rstrun_accept got=no_accept want=accept"); end
      @(posedge clk); #1;          // now in the second RUN cycle
      #2 rst_n = 1'b0;
      #1;
      total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL rstrun_in_ready got=%b want=1", in_ready); end
      total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rstrun_out_valid got=%b want=0", out_valid); end
      total++; if (D !== 16'h0000) begin bad++; $display("FAIL rstrun_D got=%h want=0000", D); end
      sb.delete();
      #1 rst_n = 1'b1;
      seen = 0;
      for (int c = 0; c < 10; c++) begin
         @(posedge clk); #1;
         if (out_valid === 1'b1) seen++;
      end
      total++; if (seen !== 0) begin bad++; $display("FAIL rstrun_no_result got=%0d want=0 out_valid cycles", seen); end
      $display("reset mid-run: discarded, out_valid cycles after reset=%0d", seen);
      send(16'hA5A5, 16'h0F0F, model(16'hA5A5, 16'h0F0F), ok);
      total++; if (!ok) begin bad++; $display("FAIL rstrun_next_accept got=no_accept want=accept"); end
      wait_out(1'b0, lat);
      pop_exp(e);
      total++; if (lat !== 4) begin bad++; $display("FAIL rstrun_next_latency got=%0d want=4", lat); end
      total++; if (D !== e.d || Borrow !== e.bor || Overflow !== e.ovf) begin
         bad++; $display("FAIL rstrun_next_result got=%h/%b/%b want=%h/%b/%b", D, Borrow, Overflow, e.d, e.bor, e.ovf);
      end
      $display("after reset: A=a5a5 B=0f0f D=%h Borrow=%b Overflow=%b", D, Borrow, Overflow);
      take_result();
   endtask

   task automatic test_input_change;
      exp_t e;
      bit   ok;
      int   lat;
      send(16'h0010, 16'h0001, '{d: 16'h000F, bor: 1'b0, ovf: 1'b0}, ok);
      total++; if (!ok) begin bad++; $display("FAIL chg_accept got=no_accept want=accept"); end
      wait_out(1'b1, lat);
      pop_exp(e);
      total++; if (lat !== 4) begin bad++; $display("FAIL chg_latency got=%0d want=4", lat); end
      total++; if (D !== e.d) begin bad++; $display("FAIL chg_D got=%h want=%h", D, e.d); end
      total++; if (Borrow !== e.bor) begin bad++; $display("FAIL chg_Borrow got=%b want=%b", Borrow, e.bor); end
      total++; if (Overflow !== e.ovf) begin bad++; $display("FAIL chg_Overflow got=%b want=%b", Overflow, e.ovf); end
      $display("input change: A=0010 B=0001 D=%h Borrow=%b Overflow=%b", D, Borrow, Overflow);
      take_result();
   endtask

   task automatic test_back_to_back;
      exp_t         e;
      bit           ok;
      int           lat;
      logic [W-1:0] a;
      logic [W-1:0] b;
      out_ready = 1'b1;
      a = W'($urandom);
      b = W'($urandom);
      for (int n = 0; n < 8; n++) begin
         send(a, b, model(a, b), ok);
         total++; if (!ok) begin bad++; $display("FAIL b2b%0d_accept got=no_accept want=accept", n); end
         wait_out(1'b0, lat);
         pop_exp(e);
         total++; if (lat !== 4) begin bad++; $display("FAIL b2b%0d_latency got=%0d want=4", n, lat); end
         total++; if (D !== e.d || Borrow !== e.bor || Overflow !== e.ovf) begin
            bad++; $display("FAIL b2b%0d_result A=%h B=%h got=%h/%b/%b want=%h/%b/%b",
                            n, a, b, D, Borrow, Overflow, e.d, e.bor, e.ovf);
         end
         $display("b2b: A=%h B=%h D=%h Borrow=%b Overflow=%b", a, b, D, Borrow, Overflow);
         // Offer the next pair during the DONE->IDLE edge: it must not be taken there.
         a = W'($urandom);
         b = W'($urandom);
         A = a; B = b; in_valid = 1'b1;
         @(posedge clk); #1;
         total++; if (in_ready !== 1'b1) begin
            bad++; $display("FAIL b2b%0d_no_accept_on_return got in_ready=%b want=1", n, in_ready);
         end
      end
      in_valid  = 1'b0;
      out_ready = 1'b0;
      @(posedge clk); #1;
   endtask

   initial begin
      test_reset();
      test_basic();
      test_overflow();
      test_backpressure();
      test_reset_midrun();
      test_input_change();
      test_back_to_back();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule : tb_serial_subtractor

// File: doc/serial_subtractor.md
SERIAL_SUBTRACTOR -- requirements
Module: serial_subtractor

Interface
REQ-001 The module SHALL have parameter WIDTH, default 16, operand/result width in bits.
REQ-002 The module SHALL have parameter CHUNK, default 4, bits processed per cycle; WIDTH % CHUNK == 0 and WIDTH >= 2 are required, and any other value is illegal.
REQ-003 The module SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-004 The module SHALL have port rst_n, input, 1, reset; asynchronous, active-low.
REQ-005 The module SHALL have port in_valid, input, 1, operands present.
REQ-006 The module SHALL have port in_ready, output, 1, block can accept operands.
REQ-007 The module SHALL have ports A and B, input, WIDTH each, minuend and subtrahend.
REQ-008 The module SHALL have port out_valid, output, 1, result present.
REQ-009 The module SHALL have port out_ready, input, 1, consumer takes result.
REQ-010 The module SHALL have port D, output, WIDTH, difference A - B, modulo 2^WIDTH.
REQ-011 The module SHALL have port Borrow, output, 1, unsigned A < B.
REQ-012 The module SHALL have port Overflow, output, 1, signed two's-complement overflow of A - B.

Function
REQ-013 The FSM SHALL have exactly three states, IDLE, RUN and DONE.
REQ-014 The FSM SHALL change state as follows: IDLE->RUN on in_valid & in_ready; RUN->DONE after NCHUNK = WIDTH/CHUNK RUN cycles; DONE->IDLE on out_ready.
REQ-015 in_ready SHALL be 1 only in IDLE, and out_valid SHALL be 1 only in DONE.
REQ-016 On accept, the block SHALL capture A and ~B, and the internal carry SHALL be initialised to 1, so that A - B = A + ~B + 1.
REQ-017 Each RUN cycle SHALL add one CHUNK-bit slice, LSB slice first, using carry-in from the previous slice, and SHALL register the slice sum and carry-out.
REQ-018 Latency SHALL be fixed: out_valid rises exactly NCHUNK clock edges after the accepting edge (4 for defaults).
REQ-019 Borrow SHALL be the inverse of the final slice carry-out.
REQ-020 Overflow SHALL be (A[MSB] != B[MSB]) && (raw D[MSB] != A[MSB]).
REQ-021 D, Borrow and Overflow SHALL stay stable while out_valid=1 and out_ready=0 (back-pressure holds the result indefinitely).
REQ-022 No accept SHALL occur in the DONE->IDLE cycle; a new operand pair is accepted no earlier than the cycle after the return to IDLE.
REQ-023 Changes on A/B/in_valid after the accept SHALL NOT affect the result in flight.
REQ-024 A slice-counter wrap SHALL NOT occur; the counter saturates at NCHUNK-1 and restarts at 0 on each accept.

Reset
REQ-025 Assertion of rst_n=0 SHALL, asynchronously and at any time including mid-RUN or in DONE, force state to IDLE, the slice counter to 0, and the operand/result registers to 0.
REQ-026 Reset values SHALL be in_ready=1, out_valid=0, D=0, Borrow=0 and Overflow=0.
REQ-027 Any in-flight operation SHALL be discarded on reset and SHALL never produce out_valid.

Configuration
REQ-028 The module SHALL support the macro SERIAL_SUBTRACTOR_SAT_EN.
REQ-029 When SERIAL_SUBTRACTOR_SAT_EN is defined and Overflow=1, D SHALL be saturated to 0x7FFF (for WIDTH=16) if A is non-negative, else to 0x8000; Borrow and Overflow are unchanged.
REQ-030 When SERIAL_SUBTRACTOR_SAT_EN is not defined, D SHALL always be the wrapped modulo result.

Structure
REQ-031 The state enumeration (IDLE, RUN, DONE) and the default WIDTH/CHUNK constants SHALL reside in the shared package alu_pkg.
REQ-032 A single sub-module, chunk_adder, SHALL implement the combinational CHUNK-bit adder (a, b, cin -> s, cout), instantiated once and reused on every RUN cycle.

Verification
REQ-033 The bench SHALL check: A=0x0005, B=0x0007 -> D=0xFFFE, Borrow=1, Overflow=0, with out_valid 4 edges after accept.
REQ-034 The bench SHALL check: A=0x8000, B=0x0001 -> Overflow=1, Borrow=0; D=0x7FFF without the macro, and D=0x8000 with SERIAL_SUBTRACTOR_SAT_EN defined.
REQ-035 The bench SHALL check: A=0x7FFF, B=0xFFFF -> Overflow=1, Borrow=1; D=0x8000 without the macro, and D=0x7FFF with it defined.
REQ-036 The bench SHALL check: A=0x1234, B=0x1234, with out_ready held 0 for 10 cycles -> D=0x0000, Borrow=0, Overflow=0, and outputs stable for all 10 cycles.
REQ-037 The bench SHALL check: rst_n pulsed low in the 2nd RUN cycle -> immediate IDLE, in_ready=1, out_valid=0, and no result is emitted; the next operation is correct.
REQ-038 The bench SHALL check: A/B changed every cycle during RUN after accepting A=0x0010, B=0x0001 -> D=0x000F, Borrow=0, Overflow=0.
